// File: rtl/piezo_seq.sv
// piezo_seq: multi-channel tone sequencer for the piezo buzzer pair.
// Each channel holds a programmable {half-period, duration} note table.
// A fixed-priority arbiter picks the lowest-index requesting channel, and a
// higher-priority request pre-empts a lower one mid-song.
module piezo_seq #(
  parameter int NUM_CH   = 3,
  parameter int NOTES    = 8,
  parameter int HP_W     = 15,
  parameter int DUR_W    = 26,
  parameter int GAP_W    = 28,
  parameter int FAST_SIM = 0,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int IDX_W = (NOTES > 1) ? $clog2(NOTES) : 1,
  localparam int LEN_W = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [HP_W-1:0]   cfg_hp,
  input  logic [DUR_W-1:0]  cfg_dur,
  input  logic              cfg_len_we,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [GAP_W-1:0]  cfg_gap,
  output logic              piezo,
  output logic              piezo_n,
  output logic              active,
  output logic [CH_W-1:0]   cur_ch,
  output logic              done
);

  localparam int STEP = (FAST_SIM != 0) ? 64 : 1;
  localparam logic [CH_W:0]    NCH    = (CH_W+1)'(NUM_CH);
  localparam logic [IDX_W:0]   NIDX   = (IDX_W+1)'(NOTES);
  localparam logic [LEN_W-1:0] NNOTES = LEN_W'(NOTES);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_e;

  // note tables and per-channel song settings
  logic [HP_W-1:0]  hp_q  [NUM_CH][NOTES];
  logic [DUR_W-1:0] dur_q [NUM_CH][NOTES];
  logic [LEN_W-1:0] len_q [NUM_CH];
  logic [GAP_W-1:0] gap_q [NUM_CH];

  logic ch_ok, idx_ok, len_ok;
  assign ch_ok  = {1'b0, cfg_ch} < NCH;
  assign idx_ok = {1'b0, cfg_idx} < NIDX;
  assign len_ok = cfg_len <= NNOTES;

  // config storage; out-of-range writes are dropped, reset disables every channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        len_q[c] <= '0;
        gap_q[c] <= '0;
        for (int n = 0; n < NOTES; n++) begin
          hp_q[c][n]  <= '0;
          dur_q[c][n] <= '0;
        end
      end
    end else begin
      if (cfg_we && ch_ok && idx_ok) begin
        hp_q[cfg_ch][cfg_idx]  <= cfg_hp;
        dur_q[cfg_ch][cfg_idx] <= cfg_dur;
      end
      if (cfg_len_we && ch_ok && len_ok) begin
        len_q[cfg_ch] <= cfg_len;
        gap_q[cfg_ch] <= cfg_gap;
      end
    end
  end

  state_e           state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nx;
  logic [LEN_W-1:0] len_l_q, len_l_d;
  logic [GAP_W-1:0] gap_l_q, gap_l_d;
  logic [HP_W-1:0]  hp_w_q, hp_w_d;
  logic [DUR_W-1:0] dur_w_q, dur_w_d;
  logic [HP_W-1:0]  freq_q, freq_d;
  logic [DUR_W-1:0] durc_q, durc_d;
  logic [GAP_W-1:0] gapc_q, gapc_d;
  logic             piezo_q, piezo_d;
  logic             done_c, start, last_note;

  logic [NUM_CH-1:0] elig;
  logic              any_elig, preempt;
  logic [CH_W-1:0]   win;

  // fixed-priority arbiter: lowest-index requesting channel with a non-empty song
  always_comb begin
    elig = '0;
    win  = '0;
    for (int i = 0; i < NUM_CH; i++) elig[i] = req[i] && (len_q[i] != '0);
    for (int i = NUM_CH-1; i >= 0; i--) if (elig[i]) win = CH_W'(i);
  end

  assign any_elig  = |elig;
  assign preempt   = any_elig && (win < ch_q) && (state_q != S_IDLE);
  assign idx_nx    = idx_q + IDX_W'(1);
  assign last_note = (LEN_W'(idx_q) + LEN_W'(1)) >= len_l_q;

  // sequencer next-state: note timing, tone toggling, gap and pre-emption
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    idx_d   = idx_q;
    len_l_d = len_l_q;
    gap_l_d = gap_l_q;
    hp_w_d  = hp_w_q;
    dur_w_d = dur_w_q;
    freq_d  = freq_q;
    durc_d  = durc_q;
    gapc_d  = gapc_q;
    piezo_d = piezo_q;
    done_c  = 1'b0;
    start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        piezo_d = 1'b0;
        start   = any_elig;
      end
      S_PLAY: begin
        if (preempt) begin
          start = 1'b1;
        end else begin
          freq_d = freq_q + HP_W'(STEP);
          durc_d = durc_q + DUR_W'(STEP);
          if (hp_w_q == '0) begin
            piezo_d = 1'b0;
          end else if (freq_q >= hp_w_q) begin
            piezo_d = ~piezo_q;
            freq_d  = '0;
          end
          if (durc_q >= dur_w_q) begin
            freq_d = '0;
            durc_d = '0;
            if (!last_note) begin
              idx_d   = idx_nx;
              hp_w_d  = hp_q[ch_q][idx_nx];
              dur_w_d = dur_q[ch_q][idx_nx];
              // entering a rest silences the pin from its first cycle
              if (hp_q[ch_q][idx_nx] == '0) piezo_d = 1'b0;
            end else begin
              done_c  = 1'b1;
              piezo_d = 1'b0;
              gapc_d  = '0;
              state_d = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        piezo_d = 1'b0;
        if (preempt) begin
          start = 1'b1;
        end else begin
          gapc_d = gapc_q + GAP_W'(STEP);
          if (gapc_q >= gap_l_q) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // song (re)start: latch the winner's settings and its first note
    if (start) begin
      state_d = S_PLAY;
      ch_d    = win;
      idx_d   = '0;
      len_l_d = len_q[win];
      gap_l_d = gap_q[win];
      hp_w_d  = hp_q[win][0];
      dur_w_d = dur_q[win][0];
      freq_d  = '0;
      durc_d  = '0;
      gapc_d  = '0;
      piezo_d = 1'b0;
    end
  end

  // sequencer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      idx_q   <= '0;
      len_l_q <= '0;
      gap_l_q <= '0;
      hp_w_q  <= '0;
      dur_w_q <= '0;
      freq_q  <= '0;
      durc_q  <= '0;
      gapc_q  <= '0;
      piezo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      idx_q   <= idx_d;
      len_l_q <= len_l_d;
      gap_l_q <= gap_l_d;
      hp_w_q  <= hp_w_d;
      dur_w_q <= dur_w_d;
      freq_q  <= freq_d;
      durc_q  <= durc_d;
      gapc_q  <= gapc_d;
      piezo_q <= piezo_d;
    end
  end

  assign piezo   = piezo_q;
  assign piezo_n = ~piezo_q;
  assign active  = (state_q == S_PLAY);
  assign cur_ch  = ch_q;
  assign done    = done_c;

endmodule

// File: tb/tb_piezo_seq.sv
// Directed bench for piezo_seq: a STEP=1 instance and a FAST_SIM instance
// share all inputs; expected waveforms are hand-derived from the note tables.
module tb_piezo_seq;

  logic        clk, rst;
  logic [2:0]  req;
  logic        cfg_we, cfg_len_we;
  logic [1:0]  cfg_ch;
  logic [2:0]  cfg_idx;
  logic [14:0] cfg_hp;
  logic [25:0] cfg_dur;
  logic [3:0]  cfg_len;
  logic [27:0] cfg_gap;

  logic       pz0, pzn0, act0, done0;
  logic [1:0] ch0;
  logic       pz1, pzn1, act1, done1;
  logic [1:0] ch1;

  int total, passed, failed, k;

  piezo_seq #(.FAST_SIM(0)) dut (
    .clk(clk), .rst(rst), .req(req), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_idx(cfg_idx), .cfg_hp(cfg_hp), .cfg_dur(cfg_dur),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cfg_gap(cfg_gap),
    .piezo(pz0), .piezo_n(pzn0), .active(act0), .cur_ch(ch0), .done(done0));

  piezo_seq #(.FAST_SIM(1)) dut_f (
    .clk(clk), .rst(rst), .req(req), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_idx(cfg_idx), .cfg_hp(cfg_hp), .cfg_dur(cfg_dur),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cfg_gap(cfg_gap),
    .piezo(pz1), .piezo_n(pzn1), .active(act1), .cur_ch(ch1), .done(done1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_note(input logic [1:0] ch, input logic [2:0] idx,
                         input logic [14:0] hp, input logic [25:0] dur);
    cfg_we = 1'b1; cfg_ch = ch; cfg_idx = idx; cfg_hp = hp; cfg_dur = dur;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wr_len(input logic [1:0] ch, input logic [3:0] len, input logic [27:0] gap);
    cfg_len_we = 1'b1; cfg_ch = ch; cfg_len = len; cfg_gap = gap;
    tick();
    cfg_len_we = 1'b0;
  endtask

  // ch1 song: 20 cycles toggling every 5, then 12 cycles toggling every 3
  function automatic int exp_song(input int c);
    if (c < 20) return (c / 5) % 2;
    return ((c - 20) / 3) % 2;
  endfunction

  // ch2 song: tone hp=2 (10 cycles), rest (8 cycles), tone hp=2 (10 cycles)
  function automatic int exp_rest(input int c);
    if (c < 10) return (c / 3) % 2;
    if (c < 18) return 0;
    return ((c - 18) / 3) % 2;
  endfunction

  initial begin
    total = 0; passed = 0; failed = 0; k = 0;
    rst = 1'b1; req = '0;
    cfg_we = 1'b0; cfg_len_we = 1'b0; cfg_ch = '0; cfg_idx = '0;
    cfg_hp = '0; cfg_dur = '0; cfg_len = '0; cfg_gap = '0;
    tick(); tick();
    chk("rst_piezo",   32'(pz0),   32'(0));
    chk("rst_piezo_n", 32'(pzn0),  32'(1));
    chk("rst_active",  32'(act0),  32'(0));
    chk("rst_cur_ch",  32'(ch0),   32'(0));
    chk("rst_done",    32'(done0), 32'(0));
    rst = 1'b0;

    // every channel starts with len=0, so requests are ignored
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("len0_idle", 32'(act0), 32'(0));
    end
    req = '0;

    // program ch1, then attempt writes that must be dropped
    wr_note(2'd1, 3'd0, 15'd4, 26'd19);
    wr_note(2'd1, 3'd1, 15'd2, 26'd11);
    wr_len(2'd1, 4'd2, 28'd10);
    cfg_we = 1'b1; cfg_len_we = 1'b1; cfg_ch = 2'd3; cfg_idx = 3'd0;
    cfg_hp = 15'd1; cfg_dur = 26'd1; cfg_len = 4'd1; cfg_gap = 28'd0;
    tick();
    cfg_we = 1'b0; cfg_len_we = 1'b0;
    wr_len(2'd1, 4'd9, 28'd0);

    // ch1 song, first pass; active must follow req by one cycle
    req = 3'b010;
    tick();
    chk("arb_latency", 32'(act0), 32'(1));
    chk("song_cur_ch", 32'(ch0),  32'(1));
    for (int c = 0; c < 32; c++) begin
      chk($sformatf("song_pz_c%0d", c),   32'(pz0),   32'(exp_song(c)));
      chk($sformatf("song_done_c%0d", c), 32'(done0), 32'((c == 31) ? 1 : 0));
      tick();
    end
    // 11 GAP cycles plus one IDLE cycle before the replay
    for (int c = 32; c < 44; c++) begin
      chk($sformatf("gap_act_c%0d", c), 32'(act0), 32'(0));
      chk($sformatf("gap_pz_c%0d", c),  32'(pz0),  32'(0));
      chk($sformatf("gap_done_c%0d", c), 32'(done0), 32'(0));
      tick();
    end
    chk("replay_active", 32'(act0), 32'(1));

    // second pass: req[1] drops at cycle 5, the song still runs to completion
    for (int c = 0; c < 32; c++) begin
      chk($sformatf("drop_pz_c%0d", c),   32'(pz0),   32'(exp_song(c)));
      chk($sformatf("drop_done_c%0d", c), 32'(done0), 32'((c == 31) ? 1 : 0));
      if (c == 5) req = '0;
      tick();
    end
    for (int c = 32; c < 48; c++) begin
      chk($sformatf("drop_idle_c%0d", c), 32'(act0), 32'(0));
      tick();
    end

    // ch2 song with a rest note in the middle; ch0 prepared for pre-emption
    wr_note(2'd2, 3'd0, 15'd2, 26'd9);
    wr_note(2'd2, 3'd1, 15'd0, 26'd7);
    wr_note(2'd2, 3'd2, 15'd2, 26'd9);
    wr_len(2'd2, 4'd3, 28'd5);
    wr_note(2'd0, 3'd0, 15'd1, 26'd50);
    wr_len(2'd0, 4'd1, 28'd3);
    req = 3'b100;
    tick();
    chk("rest_cur_ch", 32'(ch0), 32'(2));
    for (int c = 0; c < 28; c++) begin
      chk($sformatf("rest_pz_c%0d", c),   32'(pz0),   32'(exp_rest(c)));
      chk($sformatf("rest_act_c%0d", c),  32'(act0),  32'(1));
      chk($sformatf("rest_done_c%0d", c), 32'(done0), 32'((c == 27) ? 1 : 0));
      tick();
    end
    // 6 GAP cycles + 1 IDLE cycle until the ch2 replay
    k = 0;
    while (!act0 && k < 20) begin
      tick();
      k++;
    end
    chk("ch2_replay_wait", 32'(k), 32'(7));
    tick(); tick(); tick(); tick();
    chk("pre_pz_high", 32'(pz0), 32'(1));
    req = 3'b101;
    #1;
    chk("pre_no_done", 32'(done0), 32'(0));
    tick();
    chk("pre_cur_ch", 32'(ch0),   32'(0));
    chk("pre_piezo",  32'(pz0),   32'(0));
    chk("pre_active", 32'(act0),  32'(1));
    chk("pre_done",   32'(done0), 32'(0));
    tick();
    chk("pre_r1_pz", 32'(pz0), 32'(0));
    tick();
    chk("pre_r2_pz", 32'(pz0), 32'(1));
    chk("pre_r2_done", 32'(done0), 32'(0));
    req = '0;

    // reset clears the tables; then FAST_SIM timing and async reset mid-song
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 3'b111;
    tick(); tick();
    chk("tables_cleared", 32'(act0), 32'(0));
    req = '0;
    wr_note(2'd0, 3'd0, 15'd256, 26'd10000);
    wr_len(2'd0, 4'd1, 28'd0);
    req = 3'b001;
    tick();
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("fast_pz_c%0d", c),  32'(pz1),  32'((c / 5) % 2));
      chk($sformatf("fast_act_c%0d", c), 32'(act1), 32'(1));
      if (c < 7) tick();
    end
    #3;
    rst = 1'b1;
    #1;
    chk("arst_piezo",   32'(pz1),  32'(0));
    chk("arst_piezo_n", 32'(pzn1), 32'(1));
    chk("arst_active",  32'(act1), 32'(0));
    chk("arst_act_slow", 32'(act0), 32'(0));
    chk("arst_cur_ch",  32'(ch1),  32'(0));
    tick();
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
